// File: rtl/ccm_pkg.sv
// Shared CCM constants, block types and byte-count helpers.
// Block byte 0 occupies the most significant byte of the 128-bit word.
package ccm_pkg;

    localparam int WIDTH_KEY    = 128;
    localparam int BLOCK_BYTES  = 16;
    localparam int WIDTH_NBYTES = 5;

    typedef struct packed {
        logic                    stream_idx;
        logic [WIDTH_NBYTES-1:0] nbytes;
        logic [WIDTH_KEY-1:0]    data;
    } ct_blk_t;

    // 0 and anything above a full block both mean "full block".
    function automatic logic [WIDTH_NBYTES-1:0] normalise_nbytes(input logic [WIDTH_NBYTES-1:0] nbytes);
        logic [WIDTH_NBYTES-1:0] n;
        n = nbytes;
        if (nbytes == '0 || nbytes > WIDTH_NBYTES'(BLOCK_BYTES)) begin
            n = WIDTH_NBYTES'(BLOCK_BYTES);
        end
        return n;
    endfunction

    function automatic logic [WIDTH_KEY-1:0] byte_mask(input logic [WIDTH_NBYTES-1:0] nbytes);
        logic [WIDTH_KEY-1:0] m;
        m = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (WIDTH_NBYTES'(i) < nbytes) begin
                m[WIDTH_KEY-1-8*i -: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ccm_ks_fifo.sv
// Purpose: single-stream keystream FIFO with occupancy count.
// Latency: push visible at head one cycle later; head is read combinationally.
// Backpressure: push while full is dropped, pop while empty is ignored.
module ccm_ks_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128,
    parameter int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             kill_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [OCC_W-1:0] occ,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (occ == OCC_W'(DEPTH));
    assign empty   = (occ == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!kill_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/ccm_ctr_xor.sv
// Purpose: keeps two keystream FIFOs topped up and XOR-masks plaintext into ciphertext.
// Latency: 1 cycle plaintext accept to ciphertext valid; counter requests are registered.
// Backpressure: pt_ready drops when the stream FIFO is empty or the held ct block is stalled.
module ccm_ctr_xor #(
    parameter int WIDTH_KEY    = 128,
    parameter int KS_DEPTH     = 4,
    parameter int WIDTH_NBYTES = 5
) (
    input  logic                    clk,
    input  logic                    kill_n,
    output logic                    ctr_req,
    output logic                    ctr_req_stream_idx,
    input  logic                    ks_valid,
    input  logic                    ks_stream_idx,
    input  logic [WIDTH_KEY-1:0]    ks_data,
    input  logic                    pt_valid,
    output logic                    pt_ready,
    input  logic                    pt_stream_idx,
    input  logic [WIDTH_KEY-1:0]    pt_data,
    input  logic [WIDTH_NBYTES-1:0] pt_nbytes,
    output logic                    ct_valid,
    input  logic                    ct_ready,
    output logic                    ct_stream_idx,
    output logic [WIDTH_KEY-1:0]    ct_data,
    output logic [WIDTH_NBYTES-1:0] ct_nbytes,
    output logic                    ks_overflow
);

    import ccm_pkg::*;

    localparam int OCC_W = $clog2(KS_DEPTH) + 1;
    localparam int CNT_W = OCC_W + 1;

    logic [1:0]           fifo_push;
    logic [1:0]           fifo_pop;
    logic [1:0]           fifo_full;
    logic [1:0]           fifo_empty;
    logic [WIDTH_KEY-1:0] fifo_head [2];
    logic [OCC_W-1:0]     fifo_occ  [2];

    logic                 pt_accept;

    for (genvar s = 0; s < 2; s++) begin : g_fifo
        assign fifo_push[s] = ks_valid & (ks_stream_idx == 1'(s));
        assign fifo_pop[s]  = pt_accept & (pt_stream_idx == 1'(s));

        ccm_ks_fifo #(
            .DEPTH (KS_DEPTH),
            .WIDTH (WIDTH_KEY),
            .OCC_W (OCC_W)
        ) u_fifo (
            .clk       (clk),
            .kill_n    (kill_n),
            .push      (fifo_push[s]),
            .push_data (ks_data),
            .pop       (fifo_pop[s]),
            .head      (fifo_head[s]),
            .occ       (fifo_occ[s]),
            .full      (fifo_full[s]),
            .empty     (fifo_empty[s])
        );
    end

    // ------------------------------------------------------------------
    // Counter request arbiter
    // ------------------------------------------------------------------
    logic             req_d;
    logic             req_d_idx;
    logic             last_grant;
    logic [CNT_W-1:0] committed [2];
    logic [1:0]       credit;
    logic             req_nxt;
    logic             req_idx_nxt;

    // A request is outstanding for two cycles: the cycle ctr_req is high and
    // the following cycle when its keystream is on the bus but not yet in occ.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            committed[s] = CNT_W'(fifo_occ[s])
                         + CNT_W'(ctr_req && (ctr_req_stream_idx == 1'(s)))
                         + CNT_W'(req_d && (req_d_idx == 1'(s)));
            credit[s]    = committed[s] < CNT_W'(KS_DEPTH);
        end

        req_nxt     = |credit;
        req_idx_nxt = 1'b0;
        if (&credit) begin
            if (fifo_occ[0] < fifo_occ[1]) begin
                req_idx_nxt = 1'b0;
            end else if (fifo_occ[1] < fifo_occ[0]) begin
                req_idx_nxt = 1'b1;
            end else begin
                req_idx_nxt = ~last_grant;
            end
        end else if (credit[1]) begin
            req_idx_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!kill_n) begin
            ctr_req            <= 1'b0;
            ctr_req_stream_idx <= 1'b0;
            req_d              <= 1'b0;
            req_d_idx          <= 1'b0;
            last_grant         <= 1'b1;
        end else begin
            ctr_req            <= req_nxt;
            ctr_req_stream_idx <= req_idx_nxt;
            req_d              <= ctr_req;
            req_d_idx          <= ctr_req_stream_idx;
            if (req_nxt) begin
                last_grant <= req_idx_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // XOR / mask datapath and output register
    // ------------------------------------------------------------------
    ct_blk_t                 ct_q;
    ct_blk_t                 ct_nxt;
    logic [WIDTH_NBYTES-1:0] nb_norm;

    assign pt_ready  = ~fifo_empty[pt_stream_idx] & (~ct_valid | ct_ready);
    assign pt_accept = pt_valid & pt_ready;
    assign nb_norm   = normalise_nbytes(pt_nbytes);

    always_comb begin
        ct_nxt            = ct_q;
        ct_nxt.stream_idx = pt_stream_idx;
        ct_nxt.nbytes     = nb_norm;
        ct_nxt.data       = (pt_data ^ fifo_head[pt_stream_idx]) & byte_mask(nb_norm);
    end

    always_ff @(posedge clk) begin
        if (!kill_n) begin
            ct_valid    <= 1'b0;
            ct_q        <= '0;
            ks_overflow <= 1'b0;
        end else begin
            if (pt_accept) begin
                ct_q     <= ct_nxt;
                ct_valid <= 1'b1;
            end else if (ct_ready) begin
                ct_valid <= 1'b0;
            end
            if (ks_valid && fifo_full[ks_stream_idx]) begin
                ks_overflow <= 1'b1;
            end
        end
    end

    assign ct_stream_idx = ct_q.stream_idx;
    assign ct_nbytes     = ct_q.nbytes;
    assign ct_data       = ct_q.data;

endmodule

// File: tb/tb_ccm_ctr_xor.sv
// Randomised and directed bench for ccm_ctr_xor against a queue-based keystream model.
// An in-bench upstream returns keystream exactly one cycle after each counter request.
module tb_ccm_ctr_xor;

    localparam int D = 4;

    logic         clk = 1'b0;
    logic         kill_n = 1'b0;
    logic         ctr_req, ctr_req_stream_idx;
    logic         ks_valid = 1'b0;
    logic         ks_stream_idx = 1'b0;
    logic [127:0] ks_data = '0;
    logic         pt_valid, pt_ready, pt_stream_idx;
    logic [127:0] pt_data;
    logic [4:0]   pt_nbytes;
    logic         ct_valid, ct_ready, ct_stream_idx;
    logic [127:0] ct_data;
    logic [4:0]   ct_nbytes;
    logic         ks_overflow;

    ccm_ctr_xor #(.WIDTH_KEY(128), .KS_DEPTH(D), .WIDTH_NBYTES(5)) dut (
        .clk                (clk),
        .kill_n             (kill_n),
        .ctr_req            (ctr_req),
        .ctr_req_stream_idx (ctr_req_stream_idx),
        .ks_valid           (ks_valid),
        .ks_stream_idx      (ks_stream_idx),
        .ks_data            (ks_data),
        .pt_valid           (pt_valid),
        .pt_ready           (pt_ready),
        .pt_stream_idx      (pt_stream_idx),
        .pt_data            (pt_data),
        .pt_nbytes          (pt_nbytes),
        .ct_valid           (ct_valid),
        .ct_ready           (ct_ready),
        .ct_stream_idx      (ct_stream_idx),
        .ct_data            (ct_data),
        .ct_nbytes          (ct_nbytes),
        .ks_overflow        (ks_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [127:0] q0[$];
    logic [127:0] q1[$];
    bit           m_ovf = 1'b0;
    bit           exp_ct_valid = 1'b0;
    logic         exp_ct_idx = 1'b0;
    logic [127:0] exp_ct_data = '0;
    logic [4:0]   exp_ct_nb = '0;

    // Upstream emulation controls
    bit           ks_mode = 1'b0;
    logic [127:0] ks_const = '0;
    bit           force_v = 1'b0;
    logic         force_idx = 1'b0;
    logic [127:0] force_data = '0;
    bit           pend_v = 1'b0;
    logic         pend_idx = 1'b0;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int norm_nb(input logic [4:0] nb);
        return (nb == 0 || nb > 16) ? 16 : int'(nb);
    endfunction

    function automatic logic [127:0] ref_ct(input logic [127:0] pt, input logic [127:0] ks, input logic [4:0] nb);
        logic [127:0] r;
        r = pt ^ ks;
        for (int b = norm_nb(nb); b < 16; b++) r[127-8*b -: 8] = 8'h00;
        return r;
    endfunction

    function automatic bit model_ready(input logic idx);
        int sz;
        sz = idx ? q1.size() : q0.size();
        return (sz > 0) && (!exp_ct_valid || ct_ready);
    endfunction

    task automatic model_advance();
        logic [127:0] ks;
        if (pt_valid && model_ready(pt_stream_idx)) begin
            ks           = pt_stream_idx ? q1.pop_front() : q0.pop_front();
            exp_ct_data  = ref_ct(pt_data, ks, pt_nbytes);
            exp_ct_idx   = pt_stream_idx;
            exp_ct_nb    = 5'(norm_nb(pt_nbytes));
            exp_ct_valid = 1'b1;
        end else if (ct_ready) begin
            exp_ct_valid = 1'b0;
        end
    endtask

    // Model update at the edge, then drive upstream keystream for the next cycle.
    always @(posedge clk) begin
        if (!kill_n) begin
            q0.delete(); q1.delete();
            m_ovf = 1'b0; exp_ct_valid = 1'b0; exp_ct_idx = 1'b0; exp_ct_data = '0; exp_ct_nb = '0;
        end else if (ks_valid) begin
            if ((ks_stream_idx ? q1.size() : q0.size()) < D) begin
                if (ks_stream_idx) q1.push_back(ks_data); else q0.push_back(ks_data);
            end else begin
                m_ovf = 1'b1;
            end
        end
        #1;
        ks_valid      = pend_v | force_v;
        ks_stream_idx = force_v ? force_idx : pend_idx;
        ks_data       = force_v ? force_data : (ks_mode ? ks_const : rnd128());
        force_v       = 1'b0;
        pend_v        = ctr_req;
        pend_idx      = ctr_req_stream_idx;
    end

    task automatic tick();
        model_advance();
        @(negedge clk);
    endtask

    task automatic kill_and_release(input int cycles);
        kill_n   = 1'b0;
        pt_valid = 1'b0;
        repeat (cycles) tick();
        kill_n = 1'b1;
    endtask

    task automatic test_reset();
        pt_valid = 0; pt_stream_idx = 0; pt_data = '0; pt_nbytes = '0; ct_ready = 1; kill_n = 0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (ctr_req !== 1'b0) begin n_fail++; $display("FAIL reset_ctr_req: got %b want 0", ctr_req); end
        n_tests++; if (ctr_req_stream_idx !== 1'b0) begin n_fail++; $display("FAIL reset_req_idx: got %b want 0", ctr_req_stream_idx); end
        n_tests++; if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pt_ready: got %b want 0", pt_ready); end
        n_tests++; if (ct_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ct_valid: got %b want 0", ct_valid); end
        n_tests++; if (ct_stream_idx !== 1'b0) begin n_fail++; $display("FAIL reset_ct_idx: got %b want 0", ct_stream_idx); end
        n_tests++; if (ct_data !== '0) begin n_fail++; $display("FAIL reset_ct_data: got %h want 0", ct_data); end
        n_tests++; if (ct_nbytes !== '0) begin n_fail++; $display("FAIL reset_ct_nbytes: got %0d want 0", ct_nbytes); end
        n_tests++; if (ks_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", ks_overflow); end
    endtask

    task automatic test_fill_pattern();
        ks_mode = 0;
        kill_and_release(2);
        for (int i = 0; i < 8; i++) begin
            tick(); #1;
            n_tests++;
            if (ctr_req !== 1'b1 || ctr_req_stream_idx !== 1'(i % 2)) begin
                n_fail++;
                $display("FAIL fill_req_%0d: got req=%b idx=%b want req=1 idx=%0d", i, ctr_req, ctr_req_stream_idx, i % 2);
            end
        end
        tick(); #1;
        n_tests++; if (ctr_req !== 1'b0) begin n_fail++; $display("FAIL fill_req_stop: got %b want 0", ctr_req); end
        repeat (5) begin
            tick(); #1;
            n_tests++; if (ctr_req !== 1'b0) begin n_fail++; $display("FAIL fill_req_quiet: got %b want 0", ctr_req); end
        end
        n_tests++; if (q0.size() != D || q1.size() != D) begin n_fail++; $display("FAIL fill_occ: got %0d/%0d want %0d/%0d", q0.size(), q1.size(), D, D); end
        n_tests++; if (ks_overflow !== 1'b0) begin n_fail++; $display("FAIL fill_overflow: got %b want 0", ks_overflow); end
        pt_stream_idx = 1; #1;
        n_tests++; if (pt_ready !== 1'b1) begin n_fail++; $display("FAIL fill_pt_ready1: got %b want 1", pt_ready); end
    endtask

    task automatic test_xor_full();
        logic [127:0] want;
        want = 128'hFEDCBA9876543210FEDCBA9876543210;
        ks_mode = 1; ks_const = {128{1'b1}};
        kill_and_release(2);
        repeat (14) tick();
        pt_valid = 1; pt_stream_idx = 0; pt_data = 128'h0123456789ABCDEF0123456789ABCDEF; pt_nbytes = 16; ct_ready = 1;
        #1;
        n_tests++; if (pt_ready !== 1'b1) begin n_fail++; $display("FAIL xor_pt_ready: got %b want 1", pt_ready); end
        tick(); pt_valid = 0; #1;
        n_tests++; if (ct_valid !== 1'b1) begin n_fail++; $display("FAIL xor_ct_valid: got %b want 1", ct_valid); end
        n_tests++; if (ct_data !== want) begin n_fail++; $display("FAIL xor_ct_data: got %h want %h", ct_data, want); end
        n_tests++; if (ct_stream_idx !== 1'b0 || ct_nbytes !== 5'd16) begin n_fail++; $display("FAIL xor_ct_meta: got idx=%b nb=%0d want idx=0 nb=16", ct_stream_idx, ct_nbytes); end
        tick();
    endtask

    task automatic test_mask_short();
        logic [127:0] want;
        want = {40'hAAAAAAAAAA, 88'h0};
        ks_mode = 1; ks_const = {16{8'hAA}};
        kill_and_release(2);
        repeat (14) tick();
        pt_valid = 1; pt_stream_idx = 0; pt_data = '0; pt_nbytes = 5; ct_ready = 1;
        #1;
        tick(); pt_valid = 0; #1;
        n_tests++; if (ct_data !== want) begin n_fail++; $display("FAIL mask5_data: got %h want %h", ct_data, want); end
        n_tests++; if (ct_nbytes !== 5'd5) begin n_fail++; $display("FAIL mask5_nbytes: got %0d want 5", ct_nbytes); end
        tick();
    endtask

    task automatic test_nbytes_zero();
        logic [127:0] r;
        logic [4:0]   nb_list [2];
        nb_list[0] = 5'd0; nb_list[1] = 5'd21;
        for (int k = 0; k < 2; k++) begin
            r = rnd128();
            pt_valid = 1; pt_stream_idx = 1; pt_data = r; pt_nbytes = nb_list[k]; ct_ready = 1;
            #1;
            tick(); pt_valid = 0; #1;
            n_tests++; if (ct_data !== (r ^ {16{8'hAA}})) begin n_fail++; $display("FAIL nb%0d_data: got %h want %h", nb_list[k], ct_data, r ^ {16{8'hAA}}); end
            n_tests++; if (ct_nbytes !== 5'd16 || ct_stream_idx !== 1'b1) begin n_fail++; $display("FAIL nb%0d_meta: got nb=%0d idx=%b want nb=16 idx=1", nb_list[k], ct_nbytes, ct_stream_idx); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] held;
        ks_mode = 0;
        kill_and_release(2);
        repeat (14) tick();
        pt_valid = 1; pt_stream_idx = 0; pt_data = rnd128(); pt_nbytes = 16; ct_ready = 1;
        #1;
        n_tests++; if (pt_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: got %b want 1", pt_ready); end
        tick();
        ct_ready = 0; pt_data = rnd128(); pt_nbytes = 5'($urandom_range(1, 16));
        held = exp_ct_data;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (pt_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready_%0d: got %b want 0", i, pt_ready); end
            n_tests++; if (ct_valid !== 1'b1 || ct_data !== held) begin n_fail++; $display("FAIL bp_hold_%0d: got v=%b %h want v=1 %h", i, ct_valid, ct_data, held); end
            tick();
        end
        ct_ready = 1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin pt_data = rnd128(); pt_nbytes = 5'($urandom_range(0, 20)); end
            #1;
            n_tests++; if (pt_ready !== 1'b1) begin n_fail++; $display("FAIL bp_stream_ready_%0d: got %b want 1", i, pt_ready); end
            n_tests++; if (ct_valid !== 1'b1 || ct_data !== exp_ct_data || ct_nbytes !== exp_ct_nb) begin
                n_fail++; $display("FAIL bp_stream_ct_%0d: got v=%b %h nb=%0d want v=1 %h nb=%0d", i, ct_valid, ct_data, ct_nbytes, exp_ct_data, exp_ct_nb);
            end
            tick();
        end
        pt_valid = 0; #1;
        n_tests++; if (ct_valid !== 1'b1 || ct_data !== exp_ct_data) begin n_fail++; $display("FAIL bp_last_ct: got v=%b %h want v=1 %h", ct_valid, ct_data, exp_ct_data); end
        tick(); #1;
        n_tests++; if (ct_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", ct_valid); end
    endtask

    task automatic test_overflow_kill();
        ks_mode = 0;
        kill_and_release(2);
        repeat (14) tick();
        #1;
        n_tests++; if (ks_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b want 0", ks_overflow); end
        force_v = 1; force_idx = 1; force_data = {4{32'hDEADBEEF}};
        tick(); tick(); #1;
        n_tests++; if (ks_overflow !== 1'b1 || !m_ovf) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ks_overflow); end
        for (int i = 0; i < D; i++) begin
            pt_valid = 1; pt_stream_idx = 1; pt_data = '0; pt_nbytes = 16; ct_ready = 1;
            #1;
            n_tests++; if (pt_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_ready_%0d: got %b want 1", i, pt_ready); end
            tick(); #1;
            n_tests++; if (ct_data !== exp_ct_data || ct_data === force_data) begin n_fail++; $display("FAIL ovf_drain_data_%0d: got %h want %h", i, ct_data, exp_ct_data); end
        end
        pt_valid = 0; tick(); #1;
        n_tests++; if (ks_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ks_overflow); end
        kill_n = 0; tick(); kill_n = 1; #1;
        n_tests++; if (ks_overflow !== 1'b0) begin n_fail++; $display("FAIL kill_overflow: got %b want 0", ks_overflow); end
        n_tests++; if (ct_valid !== 1'b0 || ct_data !== '0 || ct_nbytes !== '0) begin n_fail++; $display("FAIL kill_ct: got v=%b %h nb=%0d want 0", ct_valid, ct_data, ct_nbytes); end
        n_tests++; if (ctr_req !== 1'b0 || pt_ready !== 1'b0) begin n_fail++; $display("FAIL kill_ctrl: got req=%b rdy=%b want 0 0", ctr_req, pt_ready); end
        tick();
    endtask

    task automatic test_random();
        int accepted = 0;
        ks_mode = 0;
        kill_and_release(2);
        for (int c = 0; c < 400; c++) begin
            if (pt_valid && pt_ready) accepted++;
            tick();
            pt_valid = ($urandom % 4) != 0;
            pt_stream_idx = 1'($urandom % 2);
            pt_data = rnd128();
            pt_nbytes = 5'($urandom_range(0, 20));
            ct_ready = ($urandom % 3) != 0;
            #1;
            n_tests++; if (pt_ready !== model_ready(pt_stream_idx)) begin n_fail++; $display("FAIL rnd_ready_c%0d: got %b want %b", c, pt_ready, model_ready(pt_stream_idx)); end
            n_tests++; if (ct_valid !== exp_ct_valid) begin n_fail++; $display("FAIL rnd_valid_c%0d: got %b want %b", c, ct_valid, exp_ct_valid); end
            if (exp_ct_valid) begin
                n_tests++;
                if (ct_data !== exp_ct_data || ct_stream_idx !== exp_ct_idx || ct_nbytes !== exp_ct_nb) begin
                    n_fail++; $display("FAIL rnd_ct_c%0d: got %h idx=%b nb=%0d want %h idx=%b nb=%0d", c, ct_data, ct_stream_idx, ct_nbytes, exp_ct_data, exp_ct_idx, exp_ct_nb);
                end
            end
        end
        pt_valid = 0;
        tick(); #1;
        n_tests++; if (ks_overflow !== 1'b0) begin n_fail++; $display("FAIL rnd_overflow: got %b want 0", ks_overflow); end
        n_tests++; if (accepted < 100) begin n_fail++; $display("FAIL rnd_throughput: got %0d accepts want >= 100", accepted); end
    endtask

    initial begin
        test_reset();
        test_fill_pattern();
        test_xor_full();
        test_mask_short();
        test_nbytes_zero();
        test_backpressure();
        test_overflow_kill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ccm_ctr_xor.md
# ccm_ctr_xor

Keystream combiner directly downstream of the CCM counter-encryption stage. Issues counter requests upstream to keep a per-stream keystream FIFO topped up. Captures returned encrypted counter blocks, then XORs each accepted 128-bit plaintext block with the oldest keystream block of its stream. Produces ciphertext blocks, with trailing-byte masking for short final blocks, toward the MAC/output framer.

## Interface
- WIDTH_KEY, 128, block / keystream width in bits
- KS_DEPTH, 4, keystream FIFO depth per stream (power of 2, ≥2)
- WIDTH_NBYTES, 5, width of byte-count fields
- clk  in  1  single clock, rising edge
- kill_n  in  1  reset, synchronous, active-low; upstream stage gets kill = ~kill_n at top level
- ctr_req  out  1  drives upstream in_ready; one counter block requested this cycle
- ctr_req_stream_idx  out  1  drives upstream in_stream_idx
- ks_valid  in  1  upstream encrypt_en
- ks_stream_idx  in  1  upstream out_stream_idx
- ks_data  in  WIDTH_KEY  upstream encrypt_ctr_data
- pt_valid  in  1  plaintext block offered
- pt_ready  out  1  plaintext block accepted when pt_valid & pt_ready
- pt_stream_idx  in  1  stream of offered block
- pt_data  in  WIDTH_KEY  plaintext; byte 0 = bits [127:120]
- pt_nbytes  in  WIDTH_NBYTES  valid bytes, 1..16; 0 or >16 treated as 16
- ct_valid  out  1  ciphertext block held
- ct_ready  in  1  downstream accepts when ct_valid & ct_ready
- ct_stream_idx  out  1  stream of ct_data
- ct_data  out  WIDTH_KEY  ciphertext, bytes ≥ nbytes forced 0
- ct_nbytes  out  WIDTH_NBYTES  normalised byte count (1..16)
- ks_overflow  out  1  sticky error: ks_valid arrived with target FIFO full

## Operation
- Two keystream FIFOs, stream 0 and 1, each KS_DEPTH × WIDTH_KEY, with occupancy count 0..KS_DEPTH.
- Credit per stream: occ + inflight < KS_DEPTH, where inflight = 1 if ctr_req for that stream was asserted in the previous cycle.
- Request arbiter (registered outputs), at most one request per cycle:
  - If both streams have credit: pick the lower occ; on a tie, pick the opposite of the last granted stream (last_grant resets to 1, so stream 0 goes first).
  - If one stream has credit: request it. If neither: ctr_req = 0.
- Keystream push: when ks_valid, write ks_data into FIFO[ks_stream_idx]. If that FIFO is full, drop the data and set ks_overflow; it stays set until kill_n.
- pt_ready = FIFO[pt_stream_idx] non-empty & (~ct_valid | ct_ready). This is combinational from pt_stream_idx and registered state.
- On accept, register in one cycle:
  - ct_data = (pt_data ^ FIFO head) with masked bytes zeroed
  - ct_stream_idx and ct_nbytes set from the accepted block
  - pop the FIFO head
- ct_valid: set on accept; cleared on ct_ready with no new accept; stays 1 on back-to-back accept with ct_ready.
- Same-cycle push and pop on one FIFO: allowed, occ unchanged. A pop of the only entry is legal while a push to it is in progress.
- Stream FIFOs are fully independent; no reordering within a stream.

## Timing
- Reset values: ctr_req 0, ctr_req_stream_idx 0, pt_ready 0, ct_valid 0, ct_stream_idx 0, ct_data 0, ct_nbytes 0, ks_overflow 0. All occ/pointers 0, last_grant 1.
- First ctr_req is asserted in the first cycle after kill_n deasserts.
- Request to keystream: the upstream returns ks_valid exactly 1 cycle after ctr_req; the credit scheme relies on this.
- Steady state: one request per cycle alternates streams while both are under depth.
- Plaintext to ciphertext latency: 1 cycle. Throughput is 1 block/cycle when keystream is available and ct_ready = 1.
- With ct_ready = 0 and ct_valid = 1: pt_ready = 0, and ct_* are held stable.
- kill_n low mid-operation: next edge clears all state and FIFO contents. Any in-flight ks_valid in the first cycle after release is ignored only if kill_n is still low.

## Structure
- Shared package ccm_pkg: WIDTH_KEY, bytes-per-block (16), and a normalise_nbytes function.
- Byte-mask function (nbytes to 128-bit mask) belongs in ccm_pkg.
- Sub-module ccm_ks_fifo: single FIFO with push/pop/occ/full/empty, instantiated twice. Arbiter, XOR/mask and output register live in the top.

## Test plan
- Reset then idle, ct_ready = 1, pt_valid = 0:
  - ctr_req pattern is 0,1,0,1… by stream.
  - After 8 cycles both occ = 4 and ctr_req = 0; ks_overflow stays 0.
- Keystream for stream 0 = 0xFF…FF; pt stream 0 data 0x0123…EF, nbytes 16 -> next cycle ct_data = 0xFEDC…10, ct_stream_idx 0.
- pt nbytes 5, data all 0x00, keystream 0xAA…AA -> ct_data = 0xAAAAAAAAAA followed by 11 zero bytes; ct_nbytes 5.
- pt_nbytes 0 -> ct_nbytes 16 and no masking.
- Hold ct_ready = 0 for 3 cycles with pt_valid high:
  - pt_ready = 0 and ct_data is held.
  - On release, blocks stream out one per cycle in order, with no loss.
- Force ks_valid on stream 1 with FIFO 1 full -> ks_overflow = 1, FIFO content unchanged. kill_n low for 1 cycle clears it and all outputs.
